// File: rtl/timer_periph_if.sv
// rtl/timer_periph_if.sv - register bus between the address decoder and the timer peripheral
interface timer_periph_if;
  logic        sel;
  logic        we;
  logic        re;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, we, re, addr, wdata, input rdata);
  modport slave  (input sel, we, re, addr, wdata, output rdata);
endinterface

// File: rtl/timer_periph.sv
// rtl/timer_periph.sv - prescaled 32-bit up-counter with compare match, overflow and level irq
module timer_periph #(
  parameter int          CNT_W   = 32,
  parameter int          PRESC_W = 8,
  parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
  input  logic           clk,
  input  logic           rst,
  timer_periph_if.slave  bus,
  output logic           irq
);
  localparam logic [1:0] A_CTRL = 2'd0, A_COUNT = 2'd1, A_CMP = 2'd2, A_STATUS = 2'd3;

  logic               en, irq_en, auto_reload, match, ovf;
  logic [PRESC_W-1:0] presc, pc;
  logic [CNT_W-1:0]   count, cmp;
  logic [31:0]        rdata_q;

  logic               en_n, irq_en_n, auto_reload_n, match_n, ovf_n, irq_n;
  logic [PRESC_W-1:0] presc_n, pc_n;
  logic [CNT_W-1:0]   count_n, cmp_n;
  logic [31:0]        rdata_n, ctrl_rd;
  logic               match_set, ovf_set;

  logic wr, rd, tick;
  logic wr_ctrl, wr_count, wr_cmp, wr_status;
  logic unused_addr_bits;

  assign wr        = bus.sel & bus.we;
  assign rd        = bus.sel & bus.re;
  assign wr_ctrl   = wr && (bus.addr[3:2] == A_CTRL);
  assign wr_count  = wr && (bus.addr[3:2] == A_COUNT);
  assign wr_cmp    = wr && (bus.addr[3:2] == A_CMP);
  assign wr_status = wr && (bus.addr[3:2] == A_STATUS);
  assign tick      = en && (pc == presc);
  assign bus.rdata = rdata_q;
  assign unused_addr_bits = ^bus.addr[1:0];

  always_comb begin
    ctrl_rd                = '0;
    ctrl_rd[0]             = en;
    ctrl_rd[1]             = irq_en;
    ctrl_rd[2]             = auto_reload;
    ctrl_rd[8 +: PRESC_W]  = presc;
  end

  always_comb begin
    en_n          = en;
    irq_en_n      = irq_en;
    auto_reload_n = auto_reload;
    presc_n       = presc;
    pc_n          = pc;
    count_n       = count;
    cmp_n         = cmp;
    match_set     = 1'b0;
    ovf_set       = 1'b0;
    rdata_n       = rdata_q;

    if (wr_ctrl) begin
      en_n          = bus.wdata[0];
      irq_en_n      = bus.wdata[1];
      auto_reload_n = bus.wdata[2];
      presc_n       = bus.wdata[8 +: PRESC_W];
    end

    if (!en || tick) pc_n = '0;
    else             pc_n = pc + PRESC_W'(1);
    // Disabling or re-timing restarts the prescale period; a tick already due still lands.
    if (wr_ctrl && (!en_n || presc_n != presc)) pc_n = '0;

    if (wr_count) begin
      count_n = bus.wdata[CNT_W-1:0];
    end else if (tick) begin
      if (count == cmp) begin
        match_set = 1'b1;
        count_n   = auto_reload ? '0 : count + CNT_W'(1);
      end else if (&count) begin
        ovf_set = 1'b1;
        count_n = '0;
      end else begin
        count_n = count + CNT_W'(1);
      end
    end

    if (wr_cmp) cmp_n = bus.wdata[CNT_W-1:0];

    // Hardware set wins over a simultaneous write-1-to-clear.
    match_n = match_set | (match & ~(wr_status & bus.wdata[0]));
    ovf_n   = ovf_set   | (ovf   & ~(wr_status & bus.wdata[1]));
    irq_n   = irq_en_n & (match_n | ovf_n);

    if (rd) begin
      case (bus.addr[3:2])
        A_CTRL:   rdata_n = ctrl_rd;
        A_COUNT:  rdata_n = 32'(count);
        A_CMP:    rdata_n = 32'(cmp);
        default:  rdata_n = {30'd0, ovf, match};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en          <= 1'b0;
      irq_en      <= 1'b0;
      auto_reload <= 1'b0;
      presc       <= '0;
      pc          <= '0;
      count       <= '0;
      cmp         <= CMP_RST[CNT_W-1:0];
      match       <= 1'b0;
      ovf         <= 1'b0;
      rdata_q     <= '0;
      irq         <= 1'b0;
    end else begin
      en          <= en_n;
      irq_en      <= irq_en_n;
      auto_reload <= auto_reload_n;
      presc       <= presc_n;
      pc          <= pc_n;
      count       <= count_n;
      cmp         <= cmp_n;
      match       <= match_n;
      ovf         <= ovf_n;
      rdata_q     <= rdata_n;
      irq         <= irq_n;
    end
  end
endmodule

// File: tb/tb_timer_periph.sv
// tb/tb_timer_periph.sv - randomized self-checking bench for timer_periph
module tb_timer_periph;
  logic clk = 1'b0;
  logic rst;
  logic irq;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  timer_periph_if bus();
  timer_periph dut (.clk(clk), .rst(rst), .bus(bus.slave), .irq(irq));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // All bus tasks start and end on a falling edge; the active edge in between is index cyc on return.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.re = 1'b0; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b0; bus.re = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.sel = 1'b0; bus.re = 1'b0;
    d = bus.rdata;
  endtask

  task automatic rw(input logic [3:0] a, input logic [31:0] wd, output logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.re = 1'b1; bus.addr = a; bus.wdata = wd;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
    d = bus.rdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1; bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    if (bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++;
    rd(4'h8, d);
    if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp got=%h exp=ffffffff", d); end
    checks++;
    for (int r = 0; r < 4; r++) begin
      if (r == 2) continue;
      rd(4'(r * 4), d);
      if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", r, d); end
      checks++;
    end
  endtask

  task automatic test_prescale;
    logic [31:0] d, exp;
    int p, w;
    for (int it = 0; it < 5; it++) begin
      p = (it == 0) ? 3 : int'($urandom_range(0, 7));
      wr(4'h0, 32'd0);
      wr(4'h4, 32'd0);
      wr(4'h0, 32'(p << 8) | 32'd1);
      w = cyc;
      idle((it == 0) ? 40 : int'($urandom_range(0, 40)));
      rd(4'h4, d);
      exp = 32'((cyc - w - 1) / (p + 1));
      if (d !== exp) begin errors++; $display("FAIL prescale p=%0d got=%0d exp=%0d", p, d, exp); end
      checks++;
    end
    wr(4'h0, 32'd0);
  endtask

  task automatic test_match_reload;
    logic [31:0] d, exp;
    int c, w;
    c = $urandom_range(2, 9);
    wr(4'h0, 32'd0); wr(4'hC, 32'd3); wr(4'h4, 32'd0); wr(4'h8, 32'(c));
    wr(4'h0, 32'h7);
    w = cyc;
    while (cyc - w <= c + 2) begin
      if (irq !== ((cyc - w) >= c + 1)) begin
        errors++; $display("FAIL match_irq k=%0d got=%b exp=%b", cyc - w, irq, (cyc - w) >= c + 1);
      end
      checks++;
      idle(1);
    end
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 12));
      rd(4'h4, d);
      exp = 32'((cyc - w - 1) % (c + 1));
      if (d !== exp) begin errors++; $display("FAIL reload_count got=%0d exp=%0d", d, exp); end
      checks++;
    end
    while ((cyc + 1 - w) % (c + 1) == 0) idle(1);
    wr(4'hC, 32'd1);
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got=%b exp=0", irq); end
    checks++;
    rd(4'hC, d);
    if (d !== 32'd0) begin errors++; $display("FAIL w1c_status got=%h exp=0", d); end
    checks++;
    idle(c + 1);
    if (irq !== 1'b1) begin errors++; $display("FAIL rematch_irq got=%b exp=1", irq); end
    checks++;
    wr(4'h0, 32'd0); wr(4'hC, 32'd3);
  endtask

  task automatic test_collisions;
    logic [31:0] d, v;
    int c, w;
    c = $urandom_range(2, 6);
    wr(4'h4, 32'd0); wr(4'h8, 32'(c)); wr(4'hC, 32'd3);
    wr(4'h0, 32'h7);
    w = cyc;
    idle(c + 2);
    while ((cyc + 1 - w) % (c + 1) != 0) idle(1);
    wr(4'hC, 32'd1);
    rd(4'hC, d);
    if (d[0] !== 1'b1) begin errors++; $display("FAIL w1c_vs_set got=%b exp=1", d[0]); end
    checks++;
    wr(4'h0, 32'd0); wr(4'h8, 32'hFFFF_FFFF); wr(4'hC, 32'd3); wr(4'h0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      v = (i == 0) ? 32'h100 : 32'($urandom_range(0, 32'hFFFF_0000));
      wr(4'h4, v);
      rd(4'h4, d);
      if (d !== v) begin errors++; $display("FAIL count_write_vs_tick got=%h exp=%h", d, v); end
      checks++;
      rd(4'h4, d);
      if (d !== v + 32'd1) begin errors++; $display("FAIL count_after_write got=%h exp=%h", d, v + 32'd1); end
      checks++;
    end
    wr(4'h0, 32'd0);
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    wr(4'h0, 32'd0); wr(4'h8, 32'd0); wr(4'h4, 32'hFFFF_FFFE); wr(4'hC, 32'd3);
    wr(4'h0, 32'd1);
    rd(4'h4, d);
    if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL ovf_cnt0 got=%h exp=fffffffe", d); end
    checks++;
    rd(4'h4, d);
    if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_cnt1 got=%h exp=ffffffff", d); end
    checks++;
    rd(4'hC, d);
    if (d !== 32'd2) begin errors++; $display("FAIL ovf_status got=%h exp=2", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_masked got=%b exp=0", irq); end
    checks++;
    wr(4'h0, 32'd3);
    if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq_en got=%b exp=1", irq); end
    checks++;
    wr(4'h0, 32'd1);
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_en_clear got=%b exp=0", irq); end
    checks++;
    wr(4'h0, 32'd0); wr(4'hC, 32'd3);
  endtask

  task automatic test_regs;
    logic [31:0] d, x, v1, v2;
    for (int i = 0; i < 4; i++) begin
      x = $urandom & 32'hFFFF_FFFE;
      wr(4'h0, x);
      rd(4'h0, d);
      if (d !== (x & 32'h0000_FF06)) begin errors++; $display("FAIL ctrl_fields got=%h exp=%h", d, x & 32'h0000_FF06); end
      checks++;
    end
    wr(4'h0, 32'd0);
    v1 = $urandom; v2 = $urandom;
    wr(4'h4, v1);
    rw(4'h4, v2, d);
    if (d !== v1) begin errors++; $display("FAIL rw_same_cycle got=%h exp=%h", d, v1); end
    checks++;
    rd(4'h4, d);
    if (d !== v2) begin errors++; $display("FAIL rw_after got=%h exp=%h", d, v2); end
    checks++;
  endtask

  task automatic test_decode;
    logic [31:0] d, v1, v3;
    v1 = $urandom; v3 = $urandom;
    wr(4'h0, 32'd0);
    wr(4'h4, v1);
    rd(4'h4, d);
    bus.sel = 1'b0; bus.we = 1'b1; bus.re = 1'b1; bus.addr = 4'h4; bus.wdata = ~v1;
    @(negedge clk);
    bus.we = 1'b0; bus.re = 1'b0;
    if (bus.rdata !== v1) begin errors++; $display("FAIL unsel_rdata_hold got=%h exp=%h", bus.rdata, v1); end
    checks++;
    rd(4'h4, d);
    if (d !== v1) begin errors++; $display("FAIL unsel_write got=%h exp=%h", d, v1); end
    checks++;
    wr(4'h6, v3);
    rd(4'h7, d);
    if (d !== v3) begin errors++; $display("FAIL addr_alias got=%h exp=%h", d, v3); end
    checks++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    wr(4'h8, 32'd2); wr(4'h4, 32'd0); wr(4'hC, 32'd3); wr(4'h0, 32'h0000_0207 & 32'hFFFF_F0FF);
    idle(5);
    if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    checks++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (bus.rdata !== 32'd0 || irq !== 1'b0) begin
      errors++; $display("FAIL midreset_out rdata=%h irq=%b exp=0/0", bus.rdata, irq);
    end
    checks++;
    rd(4'h0, d);
    if (d !== 32'd0) begin errors++; $display("FAIL midreset_ctrl got=%h exp=0", d); end
    checks++;
    rd(4'h4, d);
    if (d !== 32'd0) begin errors++; $display("FAIL midreset_count got=%h exp=0", d); end
    checks++;
    rd(4'h8, d);
    if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midreset_cmp got=%h exp=ffffffff", d); end
    checks++;
    rd(4'hC, d);
    if (d !== 32'd0) begin errors++; $display("FAIL midreset_status got=%h exp=0", d); end
    checks++;
  endtask

  initial begin
    rst = 1'b1;
    bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset;
    test_prescale;
    test_match_reload;
    test_collisions;
    test_overflow;
    test_regs;
    test_decode;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
